clock_control: RTL
==================

// Module: clock_control
// PURPOSE
//   Front-panel run/stop/step controller that drives the control inputs of the SSEM clock generator.
//   - Inputs: raw panel push-buttons and the CPU halt (stop-instruction) signal.
//   - Outputs: stop, single_step and single_stepping for the clock generator, plus panel lamp outputs.
//   - Sits between the panel switches and the clock generator; runs on the same input clock.
// PARAMETERS
//   INPUT_CLOCK_FREQUENCY_MHZ  50     clk_in frequency in MHz
//   DEBOUNCE_US                10000  time a raw button must be stable before it is accepted, in microseconds
//   STEP_PULSE_CYCLES          2      width of the single_step pulse in clk_in cycles; minimum 1
// PORTS
//   clk_in           input   1  system clock; every register changes on its rising edge
//   reset            input   1  synchronous, active-high reset
//   run_button       input   1  raw asynchronous button, active high
//   stop_button      input   1  raw asynchronous button, active high
//   step_button      input   1  raw asynchronous button, active high
//   halt             input   1  CPU halt request, level signal in the clk_in domain; only its rising edge is used
//   stop             output  1  to the clock generator; holds its output clock low
//   single_step      output  1  to the clock generator; the generator advances on a rising edge
//   single_stepping  output  1  to the clock generator; 1 = step mode, 0 = free run
//   running_lamp     output  1  high in state RUN
//   halted_lamp      output  1  high in state HALT
// BEHAVIOUR
//   Button conditioning (one identical path per button):
//   - 2-flop synchroniser, then a stability counter.
//   - DEBOUNCE_CYCLES = INPUT_CLOCK_FREQUENCY_MHZ * DEBOUNCE_US.
//   - The debounced level changes only after the synchronised input has held one value for DEBOUNCE_CYCLES consecutive cycles.
//   - The counter restarts on any change; counter width is computed by $clog2.
//   - A press event is a 1-cycle strobe on the 0->1 transition of the debounced level. Holding a button produces no further events.
//   - A halt event is a 1-cycle strobe on the 0->1 transition of halt, using a 1-flop edge detector. halt is not synchronised.
//   State machine (2-bit register) and registered outputs:
//     state  stop  single_stepping  running_lamp  halted_lamp
//     IDLE   1     1                0             0
//     RUN    0     0                1             0
//     STEP   0     1                0             0
//     HALT   1     1                0             1
//   Transitions:
//   - Evaluated in the cycle an event strobe is high.
//   - State and outputs update on the next rising edge of clk_in.
//   - Priority when events coincide: halt > stop > run > step.
//     IDLE: run -> RUN; step -> STEP and start a step pulse; halt and stop are ignored.
//     RUN : halt -> HALT; stop -> STEP (paused, no pulse); run and step are ignored.
//     STEP: halt -> HALT; run -> RUN; step -> start a pulse; stop is ignored.
//     HALT: run -> RUN; step -> STEP with no pulse; stop and halt are ignored.
//   Step pulse:
//   - single_step goes high on the same edge as the state/output update.
//   - It stays high for exactly STEP_PULSE_CYCLES cycles.
//   - A step event while a pulse is in progress is dropped; it neither extends nor re-arms the pulse.
//   - Leaving STEP (halt or run) clears single_step on that same edge.
//   - single_step is always 0 outside STEP.
//   Reset:
//   - Forces state IDLE and clears single_step, all synchronisers, debounce counters, debounced levels and the halt edge flop.
//   - Outputs after reset: stop=1, single_stepping=1, single_step=0, running_lamp=0, halted_lamp=0.
//   - Reset takes effect mid-pulse and mid-debounce; a button held through reset yields no event until it is released and pressed again.
//   Latency: a clean raw edge reaches the outputs after 2 + DEBOUNCE_CYCLES + 2 cycles.
// TESTING  (INPUT_CLOCK_FREQUENCY_MHZ=50, DEBOUNCE_US=1 -> DEBOUNCE_CYCLES=50, STEP_PULSE_CYCLES=2)
//   1. Assert reset for 1 cycle, buttons low -> stop=1, single_stepping=1, single_step=0, both lamps 0.
//   2. From IDLE, toggle step_button every 10 cycles for 200 cycles, then hold it high for 100 cycles
//      -> exactly one single_step pulse, 2 cycles wide; single_stepping=1, stop=0.
//   3. From STEP, clean run press -> stop=0, single_stepping=0, running_lamp=1.
//      Then raise halt -> one cycle later stop=1, halted_lamp=1, running_lamp=0.
//   4. In RUN, run_button and stop_button debounced events on the same cycle as the halt rising edge -> HALT.
//      Then a step press -> STEP with no single_step pulse; a second step press -> one 2-cycle pulse.
//   5. In STEP, a step event on the 2nd cycle of a pulse -> pulse still exactly 2 cycles, no second pulse.
//      Assert reset during a later pulse -> single_step=0 and state IDLE on that edge.
//   6. Hold step_button high across reset -> no pulse and state stays IDLE.
//      Release it for more than 50 cycles, then press -> STEP with one pulse.

Source files
------------

// File: rtl/clock_control.sv
// Front-panel run/stop/step controller for the SSEM clock generator.
// Debounces the panel buttons, edge-detects halt and drives the generator's control inputs.
module clock_control #(
  parameter int unsigned INPUT_CLOCK_FREQUENCY_MHZ = 50,
  parameter int unsigned DEBOUNCE_US               = 10000,
  parameter int unsigned STEP_PULSE_CYCLES         = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic run_button,
  input  logic stop_button,
  input  logic step_button,
  input  logic halt,
  output logic stop,
  output logic single_step,
  output logic single_stepping,
  output logic running_lamp,
  output logic halted_lamp
);

  localparam int unsigned DEBOUNCE_CYCLES = INPUT_CLOCK_FREQUENCY_MHZ * DEBOUNCE_US;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned PULSE_W = (STEP_PULSE_CYCLES > 1) ? $clog2(STEP_PULSE_CYCLES) : 1;
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(STEP_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StStep, StHalt} state_e;

  // Bit 0 = run, bit 1 = stop, bit 2 = step.
  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q, last_q;
  logic [2:0]       level_q, prev_q, armed_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [1:0]       fill_q;
  logic [2:0]       press;
  logic             halt_q;
  logic             halt_ev, run_ev, stop_ev, step_ev;

  state_e             state_q, state_d;
  logic               step_q, step_d;
  logic [PULSE_W-1:0] pcnt_q, pcnt_d;
  logic               start;

  assign raw = {step_button, stop_button, run_button};

  // A button is armed only once it has been seen released after reset, so a button held
  // through reset produces no event. fill_q marks the synchroniser as refilled after reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      last_q  <= '0;
      level_q <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      fill_q  <= '0;
      halt_q  <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      prev_q  <= level_q;
      fill_q  <= {fill_q[0], 1'b1};
      halt_q  <= halt;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != last_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          level_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
        if (fill_q[1] && !sync2_q[i]) armed_q[i] <= 1'b1;
      end
    end
  end

  assign press   = level_q & ~prev_q & armed_q;
  assign run_ev  = press[0];
  assign stop_ev = press[1];
  assign step_ev = press[2];
  assign halt_ev = halt & ~halt_q;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      StIdle: begin
        if (run_ev) begin
          state_d = StRun;
        end else if (step_ev) begin
          state_d = StStep;
          start   = 1'b1;
        end
      end
      StRun: begin
        if (halt_ev)      state_d = StHalt;
        else if (stop_ev) state_d = StStep;
      end
      StStep: begin
        if (halt_ev)                 state_d = StHalt;
        else if (run_ev)             state_d = StRun;
        else if (step_ev && !step_q) start   = 1'b1;
      end
      StHalt: begin
        if (run_ev)       state_d = StRun;
        else if (step_ev) state_d = StStep;
      end
      default: state_d = StIdle;
    endcase

    // Pulse runs only while staying in STEP; a step event mid-pulse is dropped above.
    step_d = 1'b0;
    pcnt_d = pcnt_q;
    if (start) begin
      step_d = 1'b1;
      pcnt_d = PULSE_LAST;
    end else if (state_d == StStep && step_q && pcnt_q != '0) begin
      step_d = 1'b1;
      pcnt_d = pcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q         <= StIdle;
      step_q          <= 1'b0;
      pcnt_q          <= '0;
      stop            <= 1'b1;
      single_stepping <= 1'b1;
      running_lamp    <= 1'b0;
      halted_lamp     <= 1'b0;
    end else begin
      state_q         <= state_d;
      step_q          <= step_d;
      pcnt_q          <= pcnt_d;
      stop            <= (state_d == StIdle) || (state_d == StHalt);
      single_stepping <= (state_d != StRun);
      running_lamp    <= (state_d == StRun);
      halted_lamp     <= (state_d == StHalt);
    end
  end

  assign single_step = step_q;

endmodule
